featuremap_accumulator: RTL and testbench

FEATUREMAP_ACCUMULATOR -- requirements
Module: featuremap_accumulator

---
 rtl/featuremap_pkg.sv | 28 ++
 rtl/fm_out_fifo.sv | 58 +++++
 rtl/featuremap_accumulator.sv | 122 ++++++++++++
 tb/tb_featuremap_accumulator.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/featuremap_pkg.sv
// featuremap_pkg: shared sizing helpers for the feature-map accumulator.
// Tree depth, latency, accumulator width and output clamp bounds.
package featuremap_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int acc_width(input int dw, input int n_ch);
    return dw + clog2(n_ch) + 1;
  endfunction

  function automatic int pipe_lat(input int n_ch);
    return clog2(n_ch) + 3;
  endfunction

  function automatic longint sat_max(input int dw);
    return (longint'(1) <<< (dw - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int dw);
    return -(longint'(1) <<< (dw - 1));
  endfunction

endpackage

// File: rtl/fm_out_fifo.sv
// fm_out_fifo: show-ahead output buffer with a registered head.
// A write is never visible on rd_data in the same cycle.
module fm_out_fifo
  import featuremap_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_en,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        rd_en,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        rd_valid,
  output logic [clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = clog2(DEPTH + 1);
  localparam int PW = clog2(DEPTH);
  localparam logic [PW-1:0] PTR_END = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    mem_cnt;
  logic             pop;
  logic             load;

  assign pop   = rd_valid && rd_en;
  assign load  = (mem_cnt != '0) && (!rd_valid || pop);
  assign count = mem_cnt + CW'(rd_valid);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == PTR_END) ? '0 : wr_ptr + 1'b1;
      mem_cnt <= mem_cnt + CW'(wr_en) - CW'(load);
      if (load) begin
        rd_data  <= mem[rd_ptr];
        rd_valid <= 1'b1;
        rd_ptr   <= (rd_ptr == PTR_END) ? '0 : rd_ptr + 1'b1;
      end else if (pop) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/featuremap_accumulator.sv
// featuremap_accumulator: sums per-channel conv results, adds bias,
// applies leaky ReLU and saturation, and buffers pixels with credit flow.
module featuremap_accumulator
  import featuremap_pkg::*;
#(
  parameter int N_CH        = 32,
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter logic signed [DATA_WIDTH-1:0] BIAS = '0,
  parameter int LEAKY_EN    = 1,
  parameter int LEAKY_SHIFT = 3,
  parameter int FIFO_DEPTH  = 8,
  parameter int IMG_SIZE    = 104
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic [N_CH*DATA_WIDTH-1:0] data_in,
  input  logic                       valid_in,
  output logic                       in_ready,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       valid_out,
  input  logic                       out_ready,
  output logic                       last_out
);

  localparam int L      = clog2(N_CH);
  localparam int LEAVES = 1 << L;
  localparam int ACC_W  = acc_width(DATA_WIDTH, N_CH);
  localparam int LAT    = pipe_lat(N_CH);
  localparam int CW     = clog2(FIFO_DEPTH + 1);
  localparam int FRAME  = IMG_SIZE * IMG_SIZE;
  localparam int PW     = (clog2(FRAME) > 0) ? clog2(FRAME) : 1;

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(DATA_WIDTH));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(DATA_WIDTH));
  localparam logic signed [ACC_W-1:0] BIAS_X = ACC_W'(BIAS);
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] PIX_LAST = PW'(FRAME - 1);

  logic                          accept;
  logic [LEAVES*DATA_WIDTH-1:0]  din_pad;
  logic signed [ACC_W-1:0]       node [2*LEAVES-1];
  logic signed [ACC_W-1:0]       bias_q;
  logic signed [ACC_W-1:0]       shifted;
  logic [DATA_WIDTH-1:0]         act_d;
  logic [DATA_WIDTH-1:0]         act_q;
  logic [LAT-1:0]                vld;
  logic [LAT-1:0]                lst;
  logic [PW-1:0]                 pix;
  logic [CW-1:0]                 inflight;
  logic [CW-1:0]                 fifo_count;
  logic [CW:0]                   occ;
  logic                          push;
  logic [DATA_WIDTH:0]           rd_data;

  assign accept   = valid_in && in_ready;
  assign push     = vld[LAT-1];
  assign occ      = {1'b0, fifo_count} + {1'b0, inflight};
  assign in_ready = Rst && (occ < DEPTH_C);
  assign din_pad  = (LEAVES * DATA_WIDTH)'(data_in);

  // Heap-ordered tree: leaves at LEAVES-1.., node n sums 2n+1 and 2n+2.
  for (genvar c = 0; c < LEAVES; c++) begin : g_leaf
    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) node[LEAVES-1+c] <= '0;
      else if (accept)
        node[LEAVES-1+c] <=
          ACC_W'($signed(din_pad[c*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  for (genvar n = 0; n < LEAVES - 1; n++) begin : g_node
    always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) node[n] <= '0;
      else      node[n] <= node[2*n+1] + node[2*n+2];
    end
  end

  always_comb begin
    shifted = bias_q;
    if (LEAKY_EN != 0 && bias_q < 0) shifted = bias_q >>> LEAKY_SHIFT;
    act_d = shifted[DATA_WIDTH-1:0];
    if (shifted > SAT_HI)      act_d = SAT_HI[DATA_WIDTH-1:0];
    else if (shifted < SAT_LO) act_d = SAT_LO[DATA_WIDTH-1:0];
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      bias_q   <= '0;
      act_q    <= '0;
      vld      <= '0;
      lst      <= '0;
      pix      <= '0;
      inflight <= '0;
    end else begin
      bias_q   <= node[0] + BIAS_X;
      act_q    <= act_d;
      vld      <= {vld[LAT-2:0], accept};
      lst      <= {lst[LAT-2:0], accept && (pix == PIX_LAST)};
      inflight <= inflight + CW'(accept) - CW'(push);
      if (accept) pix <= (pix == PIX_LAST) ? '0 : pix + 1'b1;
    end
  end

  fm_out_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (Clk),
    .rst_n    (Rst),
    .wr_en    (push),
    .wr_data  ({lst[LAT-1], act_q}),
    .rd_en    (out_ready),
    .rd_data  (rd_data),
    .rd_valid (valid_out),
    .count    (fifo_count)
  );

  assign data_out = rd_data[DATA_WIDTH-1:0];
  assign last_out = rd_data[DATA_WIDTH];

endmodule

// File: tb/tb_featuremap_accumulator.sv
// tb_featuremap_accumulator: scoreboard bench, leaky and linear instances
// driven with the same stream (N_CH=4, DATA_WIDTH=16, IMG_SIZE=2).
module tb_featuremap_accumulator;

  localparam int NC = 4;
  localparam int DW = 16;
  localparam logic signed [DW-1:0] BIAS_C = '0;

  logic              Clk;
  logic              Rst;
  logic [NC*DW-1:0]  data_in;
  logic              valid_in;
  logic              out_ready;
  logic              rdy  [2];
  logic              vo   [2];
  logic              lo   [2];
  logic [DW-1:0]     dout [2];

  logic [16:0]       sbq [2][$];
  logic              held [2];
  logic [17:0]       held_val [2];

  int n_cmp = 0;
  int n_bad = 0;
  int pix   = 0;

  featuremap_accumulator #(
    .N_CH(NC), .DATA_WIDTH(DW), .FRAC_BITS(8), .BIAS(BIAS_C),
    .LEAKY_EN(1), .LEAKY_SHIFT(3), .FIFO_DEPTH(8), .IMG_SIZE(2)
  ) u_dut_lk (
    .Clk(Clk), .Rst(Rst), .data_in(data_in), .valid_in(valid_in),
    .in_ready(rdy[0]), .data_out(dout[0]), .valid_out(vo[0]),
    .out_ready(out_ready), .last_out(lo[0])
  );

  featuremap_accumulator #(
    .N_CH(NC), .DATA_WIDTH(DW), .FRAC_BITS(8), .BIAS(BIAS_C),
    .LEAKY_EN(0), .LEAKY_SHIFT(3), .FIFO_DEPTH(8), .IMG_SIZE(2)
  ) u_dut_ln (
    .Clk(Clk), .Rst(Rst), .data_in(data_in), .valid_in(valid_in),
    .in_ready(rdy[1]), .data_out(dout[1]), .valid_out(vo[1]),
    .out_ready(out_ready), .last_out(lo[1])
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish by 400us");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rep4(input logic [15:0] x);
    return {4{x}};
  endfunction

  function automatic logic [15:0] model(input logic [63:0] d, input bit leaky);
    longint s;
    logic [15:0] ch;
    s = longint'(BIAS_C);
    for (int c = 0; c < NC; c++) begin
      ch = d[c*DW +: DW];
      s += longint'($signed(ch));
    end
    if (leaky && s < 0) s = s >>> 3;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  task automatic push_exp(input logic [15:0] ea, input logic [15:0] eb);
    logic lst;
    lst = (pix == 3);
    sbq[0].push_back({lst, ea});
    sbq[1].push_back({lst, eb});
    pix = (pix + 1) % 4;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [63:0] d, input logic [15:0] ea,
                      input logic [15:0] eb);
    int t;
    t = 0;
    data_in  = d;
    valid_in = 1'b1;
    @(negedge Clk);
    while (!rdy[0] && t < 300) begin
      @(negedge Clk);
      t++;
    end
    if (!rdy[0]) check("send_timeout", 0, 1);
    else push_exp(ea, eb);
    @(posedge Clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic send_rnd();
    logic [63:0] d;
    d = {$urandom, $urandom};
    send(d, model(d, 1'b1), model(d, 1'b0));
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while ((sbq[0].size() + sbq[1].size()) != 0 && t < 300) begin
      @(posedge Clk);
      #1;
      t++;
    end
    check("drain_left", sbq[0].size() + sbq[1].size(), 0);
    repeat (8) @(posedge Clk);
    #1;
  endtask

  always @(negedge Clk) begin
    logic [16:0] e;
    if (!Rst) begin
      held[0] = 1'b0;
      held[1] = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (held[k])
          check($sformatf("hold%0d", k), {vo[k], lo[k], dout[k]}, held_val[k]);
        if (vo[k] && out_ready) begin
          if (sbq[k].size() == 0) begin
            check($sformatf("extra_out%0d", k), 1, 0);
          end else begin
            e = sbq[k].pop_front();
            check($sformatf("out%0d", k), {lo[k], dout[k]}, e);
          end
        end
        held[k]     = vo[k] && !out_ready;
        held_val[k] = {vo[k], lo[k], dout[k]};
      end
    end
  end

  initial begin
    int lat;
    int nacc;
    logic [63:0] d;
    Rst       = 1'b0;
    valid_in  = 1'b0;
    data_in   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_valid", vo[k], 0);
      check("rst_last", lo[k], 0);
      check("rst_data", dout[k], 0);
      check("rst_ready", rdy[k], 0);
    end
    Rst = 1'b1;
    @(negedge Clk);
    check("ready_after_rst0", rdy[0], 1);
    check("ready_after_rst1", rdy[1], 1);
    @(posedge Clk);
    #1;

    // Unit sum and first-pixel latency.
    send(rep4(16'h0100), 16'h0400, 16'h0400);
    lat = 0;
    while (!vo[0] && lat < 20) begin
      @(posedge Clk);
      #1;
      lat++;
    end
    check("latency", lat, 6);

    send(rep4(16'hFE00), 16'hFF00, 16'hF800);
    send(rep4(16'h7FFF), 16'h7FFF, 16'h7FFF);
    send(rep4(16'h8000), 16'hC000, 16'h8000);
    drain();

    // Backpressure: credits must stop intake at exactly FIFO_DEPTH.
    out_ready = 1'b0;
    valid_in  = 1'b1;
    nacc      = 0;
    for (int i = 0; i < 30; i++) begin
      d = {$urandom, $urandom};
      data_in = d;
      @(negedge Clk);
      if (rdy[0]) begin
        push_exp(model(d, 1'b1), model(d, 1'b0));
        nacc++;
      end
      @(posedge Clk);
      #1;
    end
    valid_in = 1'b0;
    check("fill_count", nacc, 8);
    check("fill_ready", rdy[0], 0);
    check("fill_valid", vo[0], 1);
    drain();

    // Reset with pixels in flight; they must vanish.
    for (int i = 0; i < 3; i++) send_rnd();
    Rst = 1'b0;
    sbq[0].delete();
    sbq[1].delete();
    pix = 0;
    @(negedge Clk);
    check("midrst_valid", vo[0], 0);
    check("midrst_ready", rdy[0], 0);
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(negedge Clk);
    check("ready_after_midrst", rdy[0], 1);
    repeat (12) @(posedge Clk);
    #1;

    // Two frames with random downstream stalls; last on 4th and 8th.
    for (int i = 0; i < 8; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      send_rnd();
    end
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge Clk);
      #1;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
